trng_collector: RTL and testbench

TRNG_COLLECTOR -- requirements
Module: trng_collector

---
 rtl/trng_pkg.sv | 18 +
 rtl/trng_vn_corrector.sv | 39 +++
 rtl/trng_collector.sv | 180 ++++++++++++++++++
 tb/tb_trng_collector.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG collector: FSM state encoding and default
// parameter values.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_COLLECT,
        ST_HOLD,
        ST_FAIL
    } trng_state_t;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_DIV       = 4;
    localparam int DEF_WARMUP    = 256;
    localparam int DEF_REP_LIMIT = 32;

endpackage

// File: rtl/trng_vn_corrector.sv
// Von Neumann debiaser: pairs consecutive strobed samples, 01 yields 0,
// 10 yields 1, equal pairs are dropped.
module trng_vn_corrector
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic sample,
    input  logic clear,
    output logic bit_valid,
    output logic data_bit
);

    logic have_first;
    logic first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_first <= 1'b0;
            first      <= 1'b0;
        end else if (clear) begin
            have_first <= 1'b0;
            first      <= 1'b0;
        end else if (strobe) begin
            if (!have_first) begin
                have_first <= 1'b1;
                first      <= sample;
            end else begin
                have_first <= 1'b0;
            end
        end
    end

    // The first sample of an unequal pair is the debiased bit.
    assign bit_valid = strobe && have_first && !clear && (first != sample);
    assign data_bit  = first;

endmodule

// File: rtl/trng_collector.sv
// Collects debiased entropy bits into words, with source warm-up and a
// sticky repetition-count health test.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int DIV       = DEF_DIV,
    parameter int WARMUP    = DEF_WARMUP,
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_bit,
    output logic              trng_en,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              health_fail
);

    localparam logic [7:0]  DIV_LAST  = 8'(DIV - 1);
    localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);
    localparam logic [7:0]  REP_MAX   = 8'(REP_LIMIT);
    localparam logic [6:0]  BIT_LAST  = 7'(WORD_W - 1);

    trng_state_t       state;
    trng_state_t       state_next;
    logic              sync1;
    logic              sync2;
    logic [7:0]        div_cnt;
    logic              strobe;
    logic [15:0]       warm_cnt;
    logic              prev_sample;
    logic [7:0]        run_cnt;
    logic [7:0]        run_next;
    logic              rep_fail;
    logic              vn_clear;
    logic              vn_valid;
    logic              vn_bit;
    logic [6:0]        bit_cnt;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] shifted;
    logic              word_done;

    assign trng_en     = (state == ST_WARMUP) || (state == ST_COLLECT) || (state == ST_HOLD);
    assign rnd_valid   = (state == ST_HOLD);
    assign health_fail = (state == ST_FAIL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_bit;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!trng_en || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign strobe = trng_en && (div_cnt == DIV_LAST);

    // Strobes only occur while the source is enabled, so the health test
    // automatically covers exactly the warm-up, collect and hold phases.
    always_comb begin
        run_next = 8'd1;
        if (sync2 == prev_sample) begin
            run_next = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
        end
    end

    assign rep_fail = strobe && (run_next >= REP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt     <= '0;
            prev_sample <= 1'b0;
        end else if (strobe) begin
            run_cnt     <= run_next;
            prev_sample <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= '0;
        end else if (state == ST_WARMUP) begin
            warm_cnt <= warm_cnt + 16'd1;
        end else begin
            warm_cnt <= '0;
        end
    end

    // Pair state is held clear outside COLLECT, so every fresh collection
    // starts on a pair boundary and hold-time samples are dropped.
    assign vn_clear = (state != ST_COLLECT);

    trng_vn_corrector u_vn (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe    (strobe),
        .sample    (sync2),
        .clear     (vn_clear),
        .bit_valid (vn_valid),
        .data_bit  (vn_bit)
    );

    assign shifted   = {shift_reg[WORD_W-2:0], vn_bit};
    assign word_done = vn_valid && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state != ST_COLLECT) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (vn_valid) begin
            shift_reg <= shifted;
            bit_cnt   <= bit_cnt + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_data <= '0;
        end else if ((state == ST_COLLECT) && (state_next == ST_HOLD)) begin
            rnd_data <= shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A health failure outranks every other transition, including en=0.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (en) state_next = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (rep_fail)                   state_next = ST_FAIL;
                else if (!en)                   state_next = ST_IDLE;
                else if (warm_cnt == WARM_LAST) state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (rep_fail)       state_next = ST_FAIL;
                else if (!en)       state_next = ST_IDLE;
                else if (word_done) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (rep_fail)       state_next = ST_FAIL;
                else if (!en)       state_next = ST_IDLE;
                else if (rnd_ready) state_next = ST_COLLECT;
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trng_collector.sv
// Self-checking bench for trng_collector: directed scenarios plus random
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_trng_collector;

    localparam int WORD_W    = 8;
    localparam int DIV       = 1;
    localparam int WARMUP    = 4;
    localparam int REP_LIMIT = 8;

    localparam int P_IDLE = 0;
    localparam int P_WARM = 1;
    localparam int P_COLL = 2;
    localparam int P_HOLD = 3;
    localparam int P_FAIL = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              raw_bit = 1'b0;
    logic              rnd_ready = 1'b0;
    logic              trng_en;
    logic [WORD_W-1:0] rnd_data;
    logic              rnd_valid;
    logic              health_fail;

    int checks = 0;
    int failures = 0;

    int         m_ph;
    logic       m_s1, m_s2, m_prev;
    int         m_div, m_warm, m_run;
    logic       m_pend[$];
    logic       m_bits[$];
    logic [7:0] m_word;

    logic last_raw = 1'b0;
    int   same_run = 0;
    logic stream_q[$];

    trng_collector #(
        .WORD_W    (WORD_W),
        .DIV       (DIV),
        .WARMUP    (WARMUP),
        .REP_LIMIT (REP_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .raw_bit     (raw_bit),
        .trng_en     (trng_en),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] packBits();
        logic [7:0] w;
        w = '0;
        foreach (m_bits[i]) w = {w[6:0], m_bits[i]};
        return w;
    endfunction

    function automatic bit modelActive();
        return (m_ph == P_WARM) || (m_ph == P_COLL) || (m_ph == P_HOLD);
    endfunction

    // True when the coming clock edge will register a repetition failure.
    function automatic bit failNext();
        return modelActive() && (m_div == DIV - 1) && (m_s2 == m_prev) && (m_run + 1 >= REP_LIMIT);
    endfunction

    task automatic modelReset();
        m_ph = P_IDLE;
        m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0;
        m_div = 0; m_warm = 0; m_run = 0;
        m_pend.delete();
        m_bits.delete();
        m_word = '0;
    endtask

    task automatic modelStep(input logic e, input logic r, input logic rdy);
        bit   strb, fail, got;
        logic smp, first, gbit;
        int   nph;
        strb = modelActive() && (m_div == DIV - 1);
        smp  = m_s2;
        fail = 1'b0; got = 1'b0; gbit = 1'b0;
        if (strb) begin
            m_run  = (smp == m_prev) ? ((m_run < 255) ? m_run + 1 : m_run) : 1;
            m_prev = smp;
            fail   = (m_run >= REP_LIMIT);
        end
        if (strb && m_ph == P_COLL) begin
            if (m_pend.size() == 0) begin
                m_pend.push_back(smp);
            end else begin
                first = m_pend.pop_front();
                if (first != smp) begin
                    got  = 1'b1;
                    gbit = first;
                end
            end
        end
        if (got) m_bits.push_back(gbit);
        nph = m_ph;
        case (m_ph)
            P_IDLE: if (e) begin nph = P_WARM; m_warm = 0; end
            P_WARM: begin
                m_warm++;
                if (fail) nph = P_FAIL;
                else if (!e) nph = P_IDLE;
                else if (m_warm == WARMUP) nph = P_COLL;
            end
            P_COLL: begin
                if (fail) nph = P_FAIL;
                else if (!e) nph = P_IDLE;
                else if (m_bits.size() == WORD_W) begin
                    nph = P_HOLD;
                    m_word = packBits();
                end
            end
            P_HOLD: begin
                if (fail) nph = P_FAIL;
                else if (!e) nph = P_IDLE;
                else if (rdy) nph = P_COLL;
            end
            default: ;
        endcase
        if (nph != P_COLL || m_ph != P_COLL) begin
            m_pend.delete();
            m_bits.delete();
        end
        m_div = modelActive() ? (m_div + 1) % DIV : 0;
        m_s2 = m_s1;
        m_s1 = r;
        m_ph = nph;
    endtask

    function automatic logic randomRaw();
        logic r;
        r = logic'($urandom_range(0, 1));
        if (same_run >= 3 && r == last_raw) r = ~r;
        return r;
    endfunction

    // Compares outputs with the model at the falling edge, then drives the
    // next inputs and advances the model across the coming rising edge.
    task automatic applyStimulus(input logic e, input logic r, input logic rdy);
        @(negedge clk);
        checkOutput("trng_en", trng_en, modelActive());
        checkOutput("rnd_valid", rnd_valid, m_ph == P_HOLD);
        checkOutput("health_fail", health_fail, m_ph == P_FAIL);
        if (m_ph == P_HOLD) checkOutput("rnd_data", rnd_data, m_word);
        en = e;
        raw_bit = r;
        rnd_ready = rdy;
        if (r == last_raw) same_run++;
        else same_run = 1;
        last_raw = r;
        modelStep(e, r, rdy);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        raw_bit = 1'b1;
        rnd_ready = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_trng_en", trng_en, 0);
        checkOutput("reset_rnd_valid", rnd_valid, 0);
        checkOutput("reset_health_fail", health_fail, 0);
        checkOutput("reset_rnd_data", rnd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        modelStep(en, raw_bit, rnd_ready);
    endtask

    task automatic loadStream(input logic [31:0] v, input int n);
        stream_q.delete();
        for (int i = n - 1; i >= 0; i--) stream_q.push_back(v[i]);
    endtask

    // Idle cycles, then en with three filler bits so that the first data bit
    // is the first sample seen in COLLECT (two sync flops plus warm-up).
    task automatic startStream();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("trng_en_before", trng_en, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("trng_en_rise", trng_en, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        foreach (stream_q[i]) applyStimulus(1'b1, stream_q[i], 1'b0);
    endtask

    task automatic toggleCycles(input int n, input logic e, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(e, ~raw_bit, rdy);
    endtask

    initial begin
        int n;
        modelReset();

        // Alternating 10/01 pairs give 1010_1010.
        doReset();
        loadStream(32'h9999, 16);
        startStream();
        toggleCycles(4, 1'b1, 1'b0);
        checkOutput("aa_valid", rnd_valid, 1);
        checkOutput("aa_data", rnd_data, 8'hAA);

        // Equal pairs interleaved with 10,10,01,01,10,01,01,10 give 1100_1001.
        doReset();
        loadStream(32'h003A46D6, 24);
        startStream();
        toggleCycles(4, 1'b1, 1'b0);
        checkOutput("c9_valid", rnd_valid, 1);
        checkOutput("c9_data", rnd_data, 8'hC9);

        // Back-pressure: word must stay put, then one ready pulse releases it.
        for (int i = 0; i < 20; i++) begin
            toggleCycles(1, 1'b1, 1'b0);
            checkOutput("hold_stable", rnd_data, 8'hC9);
        end
        toggleCycles(1, 1'b1, 1'b1);
        toggleCycles(1, 1'b1, 1'b0);
        checkOutput("xfer_valid_low", rnd_valid, 0);
        n = 0;
        while (m_ph != P_HOLD && n < 200) begin
            applyStimulus(1'b1, randomRaw(), 1'b0);
            n++;
        end
        toggleCycles(1, 1'b1, 1'b0);
        checkOutput("next_word_valid", rnd_valid, 1);

        // Drop en after five accepted bits; the re-enabled word must be fresh.
        doReset();
        loadStream(32'h266, 10);
        startStream();
        toggleCycles(2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("drop_trng_en", trng_en, 0);
        checkOutput("drop_valid", rnd_valid, 0);
        loadStream(32'h6666, 16);
        startStream();
        toggleCycles(4, 1'b1, 1'b0);
        checkOutput("fresh_valid", rnd_valid, 1);
        checkOutput("fresh_data", rnd_data, 8'h55);

        // Stuck-at-1 source trips the health test; en cannot clear it.
        doReset();
        loadStream(32'hFFFF, 16);
        startStream();
        checkOutput("stuck_health_fail", health_fail, 1);
        checkOutput("stuck_trng_en", trng_en, 0);
        checkOutput("stuck_valid", rnd_valid, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(logic'(i % 2), ~raw_bit, 1'b0);
            checkOutput("fail_sticky", health_fail, 1);
        end
        doReset();

        // A completing pair always breaks a run, so the failure lands right
        // after seven accepted bits; no valid may ever be raised.
        loadStream(32'h2666, 14);
        startStream();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput("no_valid", rnd_valid, 0);
        end
        checkOutput("near_word_fail", health_fail, 1);

        // Failure on the same edge as a HOLD transfer.
        doReset();
        loadStream(32'h9999, 16);
        startStream();
        toggleCycles(4, 1'b1, 1'b0);
        n = 0;
        while (!failNext() && n < 30) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            n++;
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("xfer_fail_health", health_fail, 1);
        checkOutput("xfer_fail_valid", rnd_valid, 0);

        // Random traffic with bounded raw runs, then a forced stuck source.
        doReset();
        for (int i = 0; i < 800; i++) begin
            applyStimulus(logic'($urandom_range(0, 39) != 0), randomRaw(), logic'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, logic'($urandom_range(0, 1)));
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
